// File: rtl/spi_write_controller.sv
// rtl/spi_write_controller.sv - SPI mode-0 initiator sending one 16-bit register-write frame per request
//
// Serialises {req_write, req_addr, req_data} MSB first onto ncs/sclk/copi.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; fields latched on the accept edge
//   req_write             frame bit 15
//   req_addr[6:0]         frame bits 14:8
//   req_data[7:0]         frame bits 7:0
//   busy                  high from the accept cycle until req_ready reasserts
//   done                  one-cycle pulse when ncs rises at frame end
//   ncs, sclk, copi       SPI bus; sclk idles low, copi changes on sclk falls

module spi_write_controller #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       ncs,
    output logic       sclk,
    output logic       copi
);

    localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [4:0]    edge_cnt, edge_cnt_nxt;
    // Bit 15 goes straight to copi at accept, so only bits 14:0 are kept.
    logic [14:0]   shreg, shreg_nxt;
    logic          ncs_nxt, sclk_nxt, copi_nxt, ready_nxt, busy_nxt, done_nxt;
    logic          div_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            edge_cnt  <= '0;
            shreg     <= '0;
            ncs       <= 1'b1;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            edge_cnt  <= edge_cnt_nxt;
            shreg     <= shreg_nxt;
            ncs       <= ncs_nxt;
            sclk      <= sclk_nxt;
            copi      <= copi_nxt;
            req_ready <= ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    assign div_last = (cnt == DIV_LAST);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        edge_cnt_nxt = edge_cnt;
        shreg_nxt    = shreg;
        ncs_nxt      = ncs;
        sclk_nxt     = sclk;
        copi_nxt     = copi;
        ready_nxt    = req_ready;
        busy_nxt     = busy;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    shreg_nxt    = {req_addr, req_data};
                    copi_nxt     = req_write;
                    ncs_nxt      = 1'b0;
                    ready_nxt    = 1'b0;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = '0;
                    edge_cnt_nxt = '0;
                    state_nxt    = SETUP;
                end
            end

            SETUP: begin
                if (div_last) begin
                    cnt_nxt      = '0;
                    sclk_nxt     = 1'b1;
                    edge_cnt_nxt = edge_cnt + 5'd1;
                    state_nxt    = SHIFT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            SHIFT: begin
                if (div_last) begin
                    cnt_nxt = '0;
                    if (sclk) begin
                        sclk_nxt = 1'b0;
                        // edge_cnt counts rises; 16 means this fall ends the frame.
                        if (edge_cnt == 5'd16) begin
                            copi_nxt  = 1'b0;
                            state_nxt = HOLD;
                        end else begin
                            copi_nxt  = shreg[14];
                            shreg_nxt = {shreg[13:0], 1'b0};
                        end
                    end else begin
                        sclk_nxt     = 1'b1;
                        edge_cnt_nxt = edge_cnt + 5'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            HOLD: begin
                if (div_last) begin
                    cnt_nxt   = '0;
                    ncs_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_write_controller.sv
// tb/tb_spi_write_controller.sv - directed self-checking bench for spi_write_controller

module tb_spi_write_controller;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       req_valid, req_ready, req_write, busy, done, ncs, sclk, copi;
    logic [6:0] req_addr;
    logic [7:0] req_data;

    logic       req_valid_b, req_ready_b, req_write_b, busy_b, done_b, ncs_b, sclk_b, copi_b;
    logic [6:0] req_addr_b;
    logic [7:0] req_data_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_write_controller #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .ncs       (ncs),
        .sclk      (sclk),
        .copi      (copi)
    );

    spi_write_controller #(.CLK_DIV(2), .GAP_CYCLES(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid_b),
        .req_ready (req_ready_b),
        .req_write (req_write_b),
        .req_addr  (req_addr_b),
        .req_data  (req_data_b),
        .busy      (busy_b),
        .done      (done_b),
        .ncs       (ncs_b),
        .sclk      (sclk_b),
        .copi      (copi_b)
    );

    // Register-file peripheral: samples on sclk rise, commits a full write frame on ncs rise.
    logic [15:0] p_sh = 16'h0000;
    int          p_cnt = 0;
    logic [7:0]  p_regs [0:4] = '{default: 8'h00};

    always @(posedge sclk_b or posedge ncs_b) begin
        if (ncs_b) begin
            if (p_cnt == 16 && p_sh[15] && p_sh[14:8] < 7'd5)
                p_regs[p_sh[10:8]] <= p_sh[7:0];
            p_cnt <= 0;
        end else begin
            p_sh  <= {p_sh[14:0], copi_b};
            p_cnt <= p_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic w, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("start_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Samples cycles 1..137 after an accept (D=4, G=4).
    // mode 0: drop req_valid; mode 1: scramble fields and pulse req_valid;
    // mode 2: present nxt as the next request with req_valid held high.
    task automatic observe(input string tag, input logic [15:0] exp, input int mode, input logic [15:0] nxt);
        logic [15:0] bits = 16'h0;
        int   rises = 0, first_rise = -1, last_rise = -1;
        int   first_low = -1, last_low = -1;
        int   done_cyc = -1, done_cnt = 0, ready_cyc = -1, bad = 0;
        logic prev_sclk = 1'b0, prev_ncs = 1'b1;
        for (int c = 1; c <= 137; c++) begin
            @(negedge clk);
            if (mode == 0 && c == 1) req_valid = 1'b0;
            if (mode == 2 && c == 1) begin
                req_write = nxt[15];
                req_addr  = nxt[14:8];
                req_data  = nxt[7:0];
            end
            if (mode == 1) begin
                if (c <= 130) begin
                    req_addr  = 7'($urandom);
                    req_data  = 8'($urandom);
                    req_write = 1'($urandom);
                    req_valid = c[0];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (sclk && !prev_sclk) begin
                bits = {bits[14:0], copi};
                rises++;
                if (first_rise < 0) first_rise = c;
                last_rise = c;
            end
            if (!ncs) begin
                if (first_low < 0) first_low = c;
                last_low = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (req_ready && ready_cyc < 0) ready_cyc = c;
            if ((ncs != prev_ncs) && (sclk || prev_sclk)) bad++;
            if (sclk && ncs) bad++;
            if (busy != (c < 137)) bad++;
            prev_sclk = sclk;
            prev_ncs  = ncs;
        end
        check({tag, "_bits"},       {16'd0, bits}, {16'd0, exp});
        check({tag, "_rises"},      rises,      16);
        check({tag, "_first_rise"}, first_rise, 5);
        check({tag, "_last_rise"},  last_rise,  125);
        check({tag, "_first_low"},  first_low,  1);
        check({tag, "_last_low"},   last_low,   132);
        check({tag, "_done_cyc"},   done_cyc,   133);
        check({tag, "_done_cnt"},   done_cnt,   1);
        check({tag, "_ready_cyc"},  ready_cyc,  137);
        check({tag, "_protocol"},   bad,        0);
    endtask

    task automatic expect_idle(input string tag);
        for (int i = 0; i < 6; i++) @(negedge clk);
        check({tag, "_idle_ncs"},  {31'd0, ncs},       32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy},      32'd0);
        check({tag, "_idle_rdy"},  {31'd0, req_ready}, 32'd1);
    endtask

    task automatic send_b(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        req_write_b = 1'b1;
        req_addr_b  = a;
        req_data_b  = d;
        req_valid_b = 1'b1;
        while (!req_ready_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid_b = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", {31'd0, done_b}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        req_valid_b = 1'b0;
        req_write_b = 1'b0;
        req_addr_b  = '0;
        req_data_b  = '0;
        repeat (3) @(negedge clk);

        check("rst_ncs",  {31'd0, ncs},       32'd1);
        check("rst_sclk", {31'd0, sclk},      32'd0);
        check("rst_copi", {31'd0, copi},      32'd0);
        check("rst_rdy",  {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy},      32'd0);
        check("rst_done", {31'd0, done},      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write frame.
        start_req(1'b1, 7'h04, 8'hA5);
        observe("s1", 16'h84A5, 0, 16'h0000);
        expect_idle("s1");

        // Back-to-back frames with req_valid held high.
        start_req(1'b1, 7'h00, 8'h3C);
        observe("s2a", 16'h803C, 2, 16'h81C3);
        observe("s2b", 16'h81C3, 0, 16'h0000);
        expect_idle("s2");

        // Reset during a frame.
        start_req(1'b1, 7'h01, 8'h77);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        check("s4_pre_ncs", {31'd0, ncs}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("s4_ncs",  {31'd0, ncs},       32'd1);
        check("s4_sclk", {31'd0, sclk},      32'd0);
        check("s4_copi", {31'd0, copi},      32'd0);
        check("s4_busy", {31'd0, busy},      32'd0);
        check("s4_rdy",  {31'd0, req_ready}, 32'd1);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("s4_no_done", dcnt, 0);

        // Read frame after the reset completes normally.
        start_req(1'b0, 7'h02, 8'hFF);
        observe("s3", 16'h02FF, 0, 16'h0000);
        expect_idle("s3");

        // Fields and req_valid churn while the frame is in flight.
        start_req(1'b1, 7'h03, 8'h5A);
        observe("s6", 16'h835A, 1, 16'h0000);
        expect_idle("s6");

        // End-to-end with the register-file peripheral, D=2 G=2.
        send_b(7'h00, 8'h11);
        send_b(7'h01, 8'h22);
        send_b(7'h02, 8'h33);
        send_b(7'h03, 8'h44);
        send_b(7'h04, 8'h80);
        send_b(7'h05, 8'hEE);
        repeat (4) @(negedge clk);
        check("s5_reg0", {24'd0, p_regs[0]}, 32'h11);
        check("s5_reg1", {24'd0, p_regs[1]}, 32'h22);
        check("s5_reg2", {24'd0, p_regs[2]}, 32'h33);
        check("s5_reg3", {24'd0, p_regs[3]}, 32'h44);
        check("s5_reg4", {24'd0, p_regs[4]}, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
